wb_scoreboard_stage: RTL
========================

Name: wb_scoreboard_stage

Overview:
- MEM/WB pipeline register plus writeback select for the LEGv8 pipelined datapath.
- Drives the register file write port (we3, wa3, wd3) directly.
- Keeps a per-register pending-write scoreboard, fed by issue events from ID, so hazard logic can tell whether a source register still has a producer in flight.
- Sits between the MEM stage and the register file; its busy outputs feed the ID-stage hazard unit.

Parameters:
N, 64, datapath width
ZR, 31, zero register index (XZR): never written, never busy

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
mem_valid  in  1  MEM stage holds a real instruction
mem_regwrite  in  1  instruction writes rd
mem_memtoreg  in  1  1 = write memory read data, 0 = write ALU result
mem_rd  in  5  destination register
mem_aluresult  in  N  ALU result from MEM
mem_readdata  in  N  data memory read data
stall  in  1  hold MEM/WB register contents
flush  in  1  load a bubble into MEM/WB
issue_valid  in  1  ID issues an instruction this cycle
issue_regwrite  in  1  issued instruction writes issue_rd
issue_rd  in  5  issued destination register
ra1  in  5  ID source register 1
ra2  in  5  ID source register 2
we3  out  1  register file write enable
wa3  out  5  register file write address
wd3  out  N  register file write data
busy1  out  1  ra1 has an uncommitted producer
busy2  out  1  ra2 has an uncommitted producer
sb_ovf  out  1  sticky scoreboard overflow flag
commit_count  out  32  number of committed register writes

Behaviour:
- All state updates on the rising clk edge. Priority: reset, then flush, then stall, then load.
- Reset (reset=0 at edge):
  - MEM/WB valid=0, rd=0, data=0.
  - All pending counters=0, sb_ovf=0, commit_count=0.
  - Result: we3=0, wa3=0, wd3=0, busy1=busy2=0.
- MEM/WB register:
  - Load: when reset=1, flush=0, stall=0, captures mem_valid, mem_regwrite, mem_rd and selected data (mem_memtoreg ? mem_readdata : mem_aluresult).
  - Select is done before the register, so latency is exactly 1 cycle from mem_* to we3/wa3/wd3.
  - Flush=1: valid cleared to 0; the other fields hold their values.
  - Stall=1 with flush=0: all fields hold.
- Write port:
  - we3 = valid & regwrite & (rd != ZR).
  - wa3 = registered rd.
  - wd3 = registered data.
  - All three are pure functions of the register contents, with no combinational path from inputs.
  - When stall holds a committing instruction, we3 stays high on every held cycle. Rewriting the same value is harmless. Its scoreboard clear is taken only on the first cycle (see below).
- Scoreboard:
  - 32 counters, 2 bits each; counter[ZR] is hardwired to 0.
  - Set event: issue_valid & issue_regwrite & issue_rd != ZR.
  - Clear event: we3 & first-cycle flag. The first-cycle flag is set when the register loads and cleared after one cycle of we3 under stall.
  - Same register, set and clear in the same cycle: counter unchanged.
  - Set only: counter+1. If the counter is already 3, it stays at 3 and sb_ovf is set to 1 (sticky until reset).
  - Clear only: counter-1. If the counter is already 0, it stays at 0 and there is no error.
  - Set and clear on different registers: both applied in the same edge.
- Busy outputs:
  - busy1 = (counter[ra1] != 0); busy2 likewise for ra2.
  - Both are combinational from current counter state; ra=ZR always gives 0.
  - No same-cycle bypass: a register being committed this cycle reads busy until the edge.
- commit_count:
  - +1 on every edge where the clear event fires.
  - Wraps from 0xFFFFFFFF to 0.
- Reset mid-operation: a pending commit is dropped (no write), counters are zeroed, and any held stall is released.

Test Plan:
1. Reset and writeback: hold reset=0 for 2 cycles, then check we3=0, busy1=0, commit_count=0. Release reset; present mem_valid=1, regwrite=1, memtoreg=0, rd=5, aluresult=507, readdata=99. Next cycle: we3=1, wa3=5, wd3=507. Repeat with memtoreg=1: wd3=99.
2. XZR handling: mem_rd=31 with regwrite=1 gives we3=0. issue_rd=31 gives busy1=0 with ra1=31, and counter[31] remains 0.
3. Scoreboard lifecycle: issue rd=3 twice in consecutive cycles gives busy1=1 with ra1=3. Commit rd=3 once: busy1 still 1. Commit rd=3 again: busy1=0 and commit_count=2.
4. Simultaneous set and clear: counter[7]=1; in the same cycle issue rd=7 and commit wa3=7. After the edge counter[7]=1 and busy1=1 with ra1=7.
5. Stall and flush:
   - Commit rd=4 with stall=1 for 3 cycles: we3 held at 1, counter[4] decrements once, commit_count +1 only.
   - Then flush=1 with stall=1: next cycle we3=0 (flush wins).
6. Overflow and reset: issue rd=9 four times with no commits: counter stays at 3 and sb_ovf=1. Assert reset=0 for one edge: sb_ovf=0, busy1=0 for ra1=9, we3=0.

Source files
------------

// File: rtl/wb_scoreboard_stage.sv
// ---------------------------------------------------------------------------
// wb_scoreboard_stage
// MEM/WB pipeline register with writeback data select, driving the register
// file write port, plus a per-register pending-write scoreboard fed by ID
// issue events so the hazard unit can see in-flight producers.
//
// Ports:
//   clk, reset (sync, active-low)
//   mem_valid/mem_regwrite/mem_memtoreg/mem_rd/mem_aluresult/mem_readdata
//     : MEM stage result being handed to writeback
//   stall, flush       : hold / bubble control for the MEM/WB register
//   issue_valid/issue_regwrite/issue_rd : ID issue event (scoreboard set)
//   ra1, ra2           : ID source registers to look up
//   we3, wa3, wd3      : register file write port
//   busy1, busy2       : source register has an uncommitted producer
//   sb_ovf             : sticky scoreboard counter saturation flag
//   commit_count       : number of committed register writes (wraps)
// ---------------------------------------------------------------------------
module wb_scoreboard_stage #(
  parameter int unsigned N  = 64,
  parameter int unsigned ZR = 31
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_valid,
  input  logic         mem_regwrite,
  input  logic         mem_memtoreg,
  input  logic [4:0]   mem_rd,
  input  logic [N-1:0] mem_aluresult,
  input  logic [N-1:0] mem_readdata,
  input  logic         stall,
  input  logic         flush,
  input  logic         issue_valid,
  input  logic         issue_regwrite,
  input  logic [4:0]   issue_rd,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         busy1,
  output logic         busy2,
  output logic         sb_ovf,
  output logic [31:0]  commit_count
);

  localparam int unsigned NREG = 32;
  localparam int unsigned CW   = 2;
  localparam logic [4:0]      ZR_IDX  = 5'(ZR);
  localparam logic [CW-1:0]   CNT_MAX = '1;

  // MEM/WB register
  logic         r_valid;
  logic         r_regwrite;
  logic [4:0]   r_rd;
  logic [N-1:0] r_data;
  logic         r_first;   // current WB occupant has not yet cleared its scoreboard entry

  // Scoreboard state
  logic [CW-1:0] r_cnt [NREG];
  logic          r_ovf;
  logic [31:0]   r_commit_cnt;

  logic            w_we3;
  logic            w_set;
  logic            w_clr;
  logic [N-1:0]    w_sel_data;
  logic [NREG-1:0] w_set_vec;
  logic [NREG-1:0] w_clr_vec;
  logic            w_ovf_hit;

  // Writeback select ahead of the register keeps latency at one cycle
  assign w_sel_data = mem_memtoreg ? mem_readdata : mem_aluresult;

  assign w_we3 = r_valid & r_regwrite & (r_rd != ZR_IDX);
  assign w_set = issue_valid & issue_regwrite & (issue_rd != ZR_IDX);
  // A stalled commit keeps we3 high but only retires its entry once
  assign w_clr = w_we3 & r_first;

  // Decode set/clear events per register; detect saturating set
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    w_ovf_hit = 1'b0;
    if (w_set) w_set_vec[issue_rd] = 1'b1;
    if (w_clr) w_clr_vec[r_rd]     = 1'b1;
    w_set_vec[ZR_IDX] = 1'b0;
    w_clr_vec[ZR_IDX] = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (w_set_vec[i] && !w_clr_vec[i] && (r_cnt[i] == CNT_MAX))
        w_ovf_hit = 1'b1;
    end
  end

  // MEM/WB register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_first    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
    end else if (stall) begin
      if (w_we3) r_first <= 1'b0;
    end else begin
      r_valid    <= mem_valid;
      r_regwrite <= mem_regwrite;
      r_rd       <= mem_rd;
      r_data     <= w_sel_data;
      r_first    <= 1'b1;
    end
  end

  // Pending-write counters; simultaneous set and clear cancel out
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == int'(ZR)) begin
          r_cnt[i] <= '0;
        end else if (w_set_vec[i] && !w_clr_vec[i]) begin
          if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (!w_set_vec[i] && w_clr_vec[i]) begin
          if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end

  // Sticky overflow flag and commit counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf        <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      if (w_ovf_hit) r_ovf <= 1'b1;
      if (w_clr)     r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  assign we3          = w_we3;
  assign wa3          = r_rd;
  assign wd3          = r_data;
  assign busy1        = (r_cnt[ra1] != '0);
  assign busy2        = (r_cnt[ra2] != '0);
  assign sb_ovf       = r_ovf;
  assign commit_count = r_commit_cnt;

endmodule
